// File: rtl/uart_tx_buffered_if.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered_if
//
// Bundles the producer-side write handshake and the transmitter status/line
// outputs of uart_tx_buffered into one interface.
//
// Handshake (valid/ready): a byte on i_Tx_Byte is transferred on a rising
// clock edge where both i_Tx_DV (valid) and o_Tx_Ready (ready) are 1. A strobe
// while o_Tx_Ready is 0 is simply ignored; the producer is not required to hold
// i_Tx_DV, and o_Tx_Ready never depends combinationally on i_Tx_DV.
//
// Signals:
//   i_Tx_DV       producer -> tx  write strobe (valid)
//   i_Tx_Byte     producer -> tx  byte to enqueue, sampled with i_Tx_DV
//   o_Tx_Ready    tx -> producer  FIFO not full (ready)
//   o_Tx_Serial   tx -> line      serial output, idle high
//   o_Tx_Active   tx -> producer  a frame is on the line
//   o_Tx_Done     tx -> producer  one-cycle pulse at end of each stop bit
//   o_Fifo_Count  tx -> producer  bytes queued, excluding the byte in flight
//   dbg_state     tx -> observer  current FSM state encoding
//
// Modports: slave = the transmitter, master = the producer/testbench.
// -----------------------------------------------------------------------------
interface uart_tx_buffered_if #(
    parameter int FIFO_DEPTH = 16
) ();

    logic                          i_Tx_DV;
    logic [7:0]                    i_Tx_Byte;
    logic                          o_Tx_Ready;
    logic                          o_Tx_Serial;
    logic                          o_Tx_Active;
    logic                          o_Tx_Done;
    logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count;
    logic [2:0]                    dbg_state;

    modport slave (
        input  i_Tx_DV,
        input  i_Tx_Byte,
        output o_Tx_Ready,
        output o_Tx_Serial,
        output o_Tx_Active,
        output o_Tx_Done,
        output o_Fifo_Count,
        output dbg_state
    );

    modport master (
        output i_Tx_DV,
        output i_Tx_Byte,
        input  o_Tx_Ready,
        input  o_Tx_Serial,
        input  o_Tx_Active,
        input  o_Tx_Done,
        input  o_Fifo_Count,
        input  dbg_state
    );

endinterface

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//
// Buffered UART transmitter. Bytes written through the interface are queued in
// a small circular FIFO and serialised as 8N1 frames (start 0, 8 data bits LSB
// first, stop 1). Queued bytes go out back-to-back: the edge that ends a stop
// bit starts the next start bit when the FIFO is non-empty.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit
// (XOR of the data bits) between bit 7 and the stop bit, giving 11-bit frames.
// Without it the PARITY state and its logic are not built.
//
// Parameters:
//   CLKS_PER_BIT  clocks per bit period, 4..2047
//   FIFO_DEPTH    FIFO entries, power of two, 2..256
//
// Ports:
//   i_Clock    system clock, rising edge
//   i_Reset_n  asynchronous active-low reset (release synchronised externally)
//   bus        uart_tx_buffered_if slave modport (write handshake + status)
//
// All outputs are registered. o_Tx_Serial, o_Tx_Active and o_Tx_Done are
// loaded from the *next* FSM state so they change on the same edge as the
// state transition (e.g. the start bit appears on the pop edge).
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    uart_tx_buffered_if.slave bus
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CKW  = $clog2(CLKS_PER_BIT);

    localparam logic [CKW-1:0]  CLK_LAST   = CKW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            ready;
    logic            wr_en;
    logic            pop;
    logic            fifo_empty;
    logic [7:0]      pop_data;

    // Ready comes from the pre-edge count only, so a write while full is
    // dropped even if the FSM pops in the same cycle.
    assign ready      = (count != FULL_COUNT);
    assign wr_en      = bus.i_Tx_DV && ready;
    assign fifo_empty = (count == '0);
    assign pop_data   = mem[rd_ptr];

    // Storage needs no reset: count gates every read.
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.i_Tx_Byte;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap at FIFO_DEPTH for free.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Transmit FSM
    // -------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CKW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            serial_q, serial_d;
    logic            active_q, active_d;
    logic            done_q, done_d;
    logic            bit_end;

    assign bit_end = (clk_cnt_q == CLK_LAST);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        pop       = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shreg_d   = pop_data;
                    bit_idx_d = '0;
                    clk_cnt_d = '0;
                    state_d   = ST_START;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = ST_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`endif

            ST_STOP: begin
                if (bit_end) begin
                    done_d    = 1'b1;
                    clk_cnt_d = '0;
                    // Chain straight into the next start bit to avoid a gap.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shreg_d   = pop_data;
                        bit_idx_d = '0;
                        state_d   = ST_START;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level for the state being entered, so it is registered in step.
        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shreg_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: serial_d = ^shreg_d;
`endif
            default:   serial_d = 1'b1;
        endcase

        active_d = (state_d != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.o_Tx_Ready   = ready;
    assign bus.o_Tx_Serial  = serial_q;
    assign bus.o_Tx_Active  = active_q;
    assign bus.o_Tx_Done    = done_q;
    assign bus.o_Fifo_Count = count;
    assign bus.dbg_state    = state_q;

endmodule
